// File: rtl/alu_sched_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : alu_sched_pkg
// Purpose  : Shared definitions for the ALU request scheduler. Holds the
//            opcode encoding that the external ALU uses, helpers that
//            classify opcodes, and the scheduler FSM state type.
// Contents : c_op_* opcode constants, is_legal_op(), is_mul(), state_t
// Revision : 1.0 - initial release
// ============================================================================
package alu_sched_pkg;

    // Opcode encoding, matching the ALU. 12..15 are unused and illegal.
    localparam logic [3:0] c_op_add  = 4'd0;
    localparam logic [3:0] c_op_sub  = 4'd1;
    localparam logic [3:0] c_op_and  = 4'd2;
    localparam logic [3:0] c_op_or   = 4'd3;
    localparam logic [3:0] c_op_nand = 4'd4;
    localparam logic [3:0] c_op_mul  = 4'd5;
    localparam logic [3:0] c_op_ror  = 4'd6;
    localparam logic [3:0] c_op_sll  = 4'd7;
    localparam logic [3:0] c_op_min  = 4'd8;
    localparam logic [3:0] c_op_sne  = 4'd9;
    localparam logic [3:0] c_op_rol  = 4'd10;
    localparam logic [3:0] c_op_xnor = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            c_op_add, c_op_sub, c_op_and, c_op_or,
            c_op_nand, c_op_mul, c_op_ror, c_op_sll,
            c_op_min, c_op_sne, c_op_rol, c_op_xnor: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

    function automatic logic is_mul(input logic [3:0] op);
        return (op == c_op_mul);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_req_sched_rr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin picker. Searches the request vector
//            starting one position after the pointer, wrapping at NUM_REQ,
//            and returns the first set bit.
// Ports    : req       [NUM_REQ]  request vector
//            ptr       [IDW]      index of the most recent grant
//            grant     [NUM_REQ]  one-hot grant (zero when nothing requested)
//            grant_idx [IDW]      index of the granted bit
//            found     [1]        at least one request present
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       found
);

    localparam int c_idw = $clog2(NUM_REQ);

    logic [c_idw-1:0] w_idx;
    int               w_sum;

    // Offsets 1..NUM_REQ from the pointer; the last offset is the pointer
    // itself, so a lone requester that was just served can win again.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        w_sum     = 0;
        w_idx     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_sum = int'(ptr) + k;
            if (w_sum >= NUM_REQ) begin
                w_sum = w_sum - NUM_REQ;
            end
            w_idx = c_idw'(w_sum);
            if (!found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                grant_idx    = w_idx;
                found        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_req_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : alu_req_sched
// Purpose  : Time-shares one external combinational ALU among NUM_REQ
//            requesters. One request is granted at a time (round-robin),
//            its fields are held on the alu_* outputs for the op latency,
//            and the ALU result/flags are returned on a valid/ready
//            response port tagged with the requester index.
// Ports    : clk, rst_n (async, active low)
//            req_valid/req_ready, req_opcode/req_a/req_b/req_shift (packed)
//            alu_opcode/alu_input1/alu_input2/alu_shift -> ALU
//            alu_result/alu_carry/alu_zero/alu_ovf      <- ALU
//            rsp_valid/rsp_ready, rsp_id, rsp_result, rsp_flags{ovf,zero,carry},
//            rsp_err (illegal opcode)
// Config   : ALU_REQ_SCHED_STATS_EN adds stat_clr (in) and grant_cnt (out,
//            16 bits per requester, saturating accept counters).
// Revision : 1.0 - initial release
// ============================================================================
module alu_req_sched
    import alu_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 16,
    parameter int MUL_LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [4*NUM_REQ-1:0]       req_opcode,
    input  logic [WIDTH*NUM_REQ-1:0]   req_a,
    input  logic [WIDTH*NUM_REQ-1:0]   req_b,
    input  logic [5*NUM_REQ-1:0]       req_shift,
    output logic [3:0]                 alu_opcode,
    output logic [WIDTH-1:0]           alu_input1,
    output logic [WIDTH-1:0]           alu_input2,
    output logic [4:0]                 alu_shift,
    input  logic [WIDTH-1:0]           alu_result,
    input  logic                       alu_carry,
    input  logic                       alu_zero,
    input  logic                       alu_ovf,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]           rsp_result,
    output logic [2:0]                 rsp_flags,
    output logic                       rsp_err
`ifdef ALU_REQ_SCHED_STATS_EN
    ,
    input  logic                       stat_clr,
    output logic [16*NUM_REQ-1:0]      grant_cnt
`endif
);

    localparam int c_idw  = $clog2(NUM_REQ);
    localparam int c_cntw = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [c_cntw-1:0] c_mul_cnt = c_cntw'(MUL_LATENCY - 1);

    state_t              r_state;
    logic [c_idw-1:0]    r_ptr;
    logic [c_cntw-1:0]   r_cnt;
    logic [3:0]          r_op;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [4:0]          r_sh;

    logic [NUM_REQ-1:0]  w_grant;
    logic [c_idw-1:0]    w_gidx;
    logic                w_found;
    logic [3:0]          w_op;
    logic [WIDTH-1:0]    w_a;
    logic [WIDTH-1:0]    w_b;
    logic [4:0]          w_sh;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_gidx),
        .found     (w_found)
    );

    // Fields of the requester that would be granted this cycle.
    assign w_op = req_opcode[int'(w_gidx) * 4 +: 4];
    assign w_a  = req_a[int'(w_gidx) * WIDTH +: WIDTH];
    assign w_b  = req_b[int'(w_gidx) * WIDTH +: WIDTH];
    assign w_sh = req_shift[int'(w_gidx) * 5 +: 5];

    // The accept strobe is combinational so the grant and the operand latch
    // happen in the same cycle. It is masked while rst_n is low so that no
    // requester sees an accept for an op the held-in-reset registers drop.
    assign req_ready = (rst_n && (r_state == IDLE)) ? w_grant : '0;

    // The ALU is driven only from registers; they change only on a grant.
    assign alu_opcode = r_op;
    assign alu_input1 = r_a;
    assign alu_input2 = r_b;
    assign alu_shift  = r_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= c_idw'(NUM_REQ - 1);
            r_cnt      <= '0;
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_sh       <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_ptr  <= w_gidx;
                        rsp_id <= w_gidx;
                        r_op   <= w_op;
                        r_a    <= w_a;
                        r_b    <= w_b;
                        r_sh   <= w_sh;
                        if (is_legal_op(w_op)) begin
                            r_state <= EXEC;
                            r_cnt   <= is_mul(w_op) ? c_mul_cnt : '0;
                        end else begin
                            // Illegal ops bypass the ALU and answer at once.
                            r_state    <= RESP;
                            rsp_valid  <= 1'b1;
                            rsp_err    <= 1'b1;
                            rsp_result <= '0;
                            rsp_flags  <= '0;
                        end
                    end
                end
                EXEC: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state    <= RESP;
                        rsp_valid  <= 1'b1;
                        rsp_err    <= 1'b0;
                        rsp_result <= alu_result;
                        rsp_flags  <= {alu_ovf, alu_zero, alu_carry};
                    end
                end
                RESP: begin
                    // Returning to IDLE costs one cycle before the next grant.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_REQ_SCHED_STATS_EN
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
        logic [15:0] r_grant_cnt;

        // Clear has priority over a same-cycle accept; counting stops at max.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_grant_cnt <= '0;
            end else if (stat_clr) begin
                r_grant_cnt <= '0;
            end else if (req_ready[gi] && (r_grant_cnt != 16'hFFFF)) begin
                r_grant_cnt <= r_grant_cnt + 16'd1;
            end
        end

        assign grant_cnt[gi*16 +: 16] = r_grant_cnt;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_req_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_alu_req_sched
// Purpose  : Self-checking bench for alu_req_sched. Provides a behavioural
//            ALU, drives directed and random requests, predicts grants by
//            round-robin and queues expected responses for a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_req_sched;

    localparam int NR  = 4;
    localparam int W   = 16;
    localparam int ML  = 3;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [4*NR-1:0]   req_opcode;
    logic [W*NR-1:0]   req_a;
    logic [W*NR-1:0]   req_b;
    logic [5*NR-1:0]   req_shift;
    logic [3:0]        alu_opcode;
    logic [W-1:0]      alu_input1;
    logic [W-1:0]      alu_input2;
    logic [4:0]        alu_shift;
    logic [W-1:0]      alu_result;
    logic              alu_carry;
    logic              alu_zero;
    logic              alu_ovf;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_result;
    logic [2:0]        rsp_flags;
    logic              rsp_err;
`ifdef ALU_REQ_SCHED_STATS_EN
    logic              stat_clr;
    logic [16*NR-1:0]  grant_cnt;
`endif

    alu_req_sched #(
        .NUM_REQ     (NR),
        .WIDTH       (W),
        .MUL_LATENCY (ML)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_shift  (req_shift),
        .alu_opcode (alu_opcode),
        .alu_input1 (alu_input1),
        .alu_input2 (alu_input2),
        .alu_shift  (alu_shift),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .alu_zero   (alu_zero),
        .alu_ovf    (alu_ovf),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .rsp_err    (rsp_err)
`ifdef ALU_REQ_SCHED_STATS_EN
        ,
        .stat_clr   (stat_clr),
        .grant_cnt  (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------- ALU
    // Returns {ovf, zero, carry, result}. Illegal opcodes return junk so a
    // response that wrongly samples the ALU for them is visible.
    function automatic logic [W+2:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [4:0] sh);
        logic [W:0]     s;
        logic [2*W-1:0] p;
        logic [W-1:0]   r;
        logic           c;
        logic           v;
        int             n;
        c = 1'b0; v = 1'b0; r = '0; s = '0; p = '0;
        n = int'(sh[3:0]);
        case (op)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W];
                        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
            4'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[W-1:0]; c = s[W];
                        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = ~(a & b);
            4'd5: begin p = a * b; r = p[W-1:0]; c = |p[2*W-1:W]; end
            4'd6: r = (n == 0) ? a : ((a >> n) | (a << (W - n)));
            4'd7: r = a << sh;
            4'd8: r = (a < b) ? a : b;
            4'd9: r = (a != b) ? W'(1) : W'(0);
            4'd10: r = (n == 0) ? a : ((a << n) | (a >> (W - n)));
            4'd11: r = ~(a ^ b);
            default: begin r = 16'hDEAD; c = 1'b1; v = 1'b1; end
        endcase
        return {v, (r == '0) && (op < 4'd12), c, r};
    endfunction

    always_comb begin
        {alu_ovf, alu_zero, alu_carry, alu_result} = alu_ref(alu_opcode, alu_input1, alu_input2, alu_shift);
    end

    // ---------------------------------------------------------- scoreboard
    typedef struct {
        int           id;
        logic [W-1:0] res;
        logic [2:0]   flags;
        logic         err;
        int           cyc;
        int           lat;
    } exp_t;

    exp_t sbq[$];
    int   grant_log[$];
    int   checks = 0;
    int   errors = 0;

    int            last_g      = NR - 1;
    int            outstanding = 0;
    logic [NR-1:0] pend_acc    = '0;
    bit            rnd_en      = 1'b0;
    bit            refill      = 1'b0;
    int            ready_mode  = 1;
    int            prev_acc    = -1;
    bit            spacing_chk = 1'b0;
    int            gcount[NR];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endfunction

    task automatic set_req(input int i, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [4:0] sh);
        req_opcode[i*4 +: 4] = op;
        req_a[i*W +: W]      = a;
        req_b[i*W +: W]      = b;
        req_shift[i*5 +: 5]  = sh;
        req_valid[i]         = 1'b1;
    endtask

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] corner[5];
        corner = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
        return W'($urandom);
    endfunction

    task automatic rand_req(input int i);
        logic [3:0] op;
        if ($urandom_range(0, 7) == 0) op = 4'($urandom_range(12, 15));
        else                           op = 4'($urandom_range(0, 11));
        set_req(i, op, rand_operand(), rand_operand(), 5'($urandom_range(0, 31)));
    endtask

    // Start of a cycle: retire accepted requests, optionally create new ones.
    task automatic adv();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (pend_acc[i]) begin
                if (refill) set_req(i, 4'd0, rand_operand(), rand_operand(), 5'd0);
                else        req_valid[i] = 1'b0;
            end else if (rnd_en) begin
                if (req_valid[i]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    rand_req(i);
                end
            end
        end
        pend_acc = '0;
    endtask

    // Mid-cycle: predict the grant and, if one is due, queue its response.
    task automatic smp();
        logic [NR-1:0] exp_rdy;
        logic [3:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        int            g;
        exp_t          e;
        #2;
        exp_rdy = '0;
        g = -1;
        if (outstanding == 0 && req_valid != '0) begin
            for (int k = 1; k <= NR; k++) begin
                int j;
                j = (last_g + k) % NR;
                if (g < 0 && req_valid[j]) g = j;
            end
            exp_rdy[g] = 1'b1;
        end
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (g >= 0) begin
            op = req_opcode[g*4 +: 4];
            a  = req_a[g*W +: W];
            b  = req_b[g*W +: W];
            e.id  = g;
            e.cyc = cyc;
            if (op >= 4'd12) begin
                e.res = '0; e.flags = '0; e.err = 1'b1; e.lat = 1;
            end else begin
                {e.flags, e.res} = alu_ref(op, a, b, req_shift[g*5 +: 5]);
                e.err = 1'b0;
                e.lat = (op == 4'd5) ? ML + 1 : 2;
            end
            sbq.push_back(e);
            grant_log.push_back(g);
            outstanding++;
            last_g      = g;
            pend_acc[g] = 1'b1;
            gcount[g]++;
            if (spacing_chk && prev_acc >= 0) chk("grant_spacing", 32'(cyc - prev_acc), 32'd3);
            prev_acc = cyc;
        end
    endtask

    task automatic step();
        adv();
        smp();
    endtask

    task automatic quiesce();
        adv();
        req_valid = '0;
        smp();
        for (int k = 0; k < 60; k++) begin
            if (outstanding == 0 && sbq.size() == 0) break;
            step();
        end
        chk("drain", 32'(sbq.size()), 32'd0);
        step();
    endtask

    // ------------------------------------------------------------ drivers
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       rsp_ready = ($urandom_range(0, 3) != 0);
                1:       rsp_ready = 1'b1;
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------ monitor
    initial begin
        bit           presenting;
        logic [21:0]  held;
        exp_t         e;
        presenting = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                presenting = 1'b0;
            end else if (rsp_valid) begin
                if (!presenting) begin
                    presenting = 1'b1;
                    held = {rsp_id, rsp_result, rsp_flags, rsp_err};
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected id=%0d result=%0h required=none t=%0t",
                                 rsp_id, rsp_result, $time);
                    end else begin
                        e = sbq.pop_front();
                        chk("rsp_id",      32'(rsp_id),     32'(e.id));
                        chk("rsp_result",  32'(rsp_result), 32'(e.res));
                        chk("rsp_flags",   32'(rsp_flags),  32'(e.flags));
                        chk("rsp_err",     32'(rsp_err),    32'(e.err));
                        chk("rsp_latency", 32'(cyc - e.cyc), 32'(e.lat));
                    end
                end else begin
                    chk("rsp_hold", 32'({rsp_id, rsp_result, rsp_flags, rsp_err}), 32'(held));
                end
                if (rsp_ready) begin
                    presenting = 1'b0;
                    if (outstanding > 0) outstanding--;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ----------------------------------------------------------- stimulus
    initial begin
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NR; i++) gcount[i] = 0;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_opcode = '0;
        req_a      = '0;
        req_b      = '0;
        req_shift  = '0;
`ifdef ALU_REQ_SCHED_STATS_EN
        stat_clr   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 req_valid = '1;
        #2;
        chk("rst_req_ready",  32'(req_ready),  32'd0);
        chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
        chk("rst_alu_ops",    32'({alu_opcode, alu_shift}), 32'd0);
        chk("rst_alu_in",     {alu_input1, alu_input2}, 32'd0);
        chk("rst_rsp_fields", 32'({rsp_id, rsp_result, rsp_flags, rsp_err}), 32'd0);
        req_valid = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // All four requesting with an always-ready sink: order 0,1,2,3,0.
        grant_log.delete();
        refill      = 1'b1;
        spacing_chk = 1'b1;
        prev_acc    = -1;
        adv();
        for (int i = 0; i < NR; i++) set_req(i, 4'd0, rand_operand(), rand_operand(), 5'd0);
        smp();
        for (int k = 0; k < 40 && grant_log.size() < 5; k++) step();
        chk("rr_grant_count", 32'(grant_log.size() >= 5), 32'd1);
        for (int k = 0; k < 5 && k < grant_log.size(); k++) chk("rr_order", 32'(grant_log[k]), 32'(exp_order[k]));
        refill      = 1'b0;
        spacing_chk = 1'b0;
        quiesce();

        // Single ADD with signed overflow.
        adv();
        set_req(0, 4'd0, 16'h7FFF, 16'h0001, 5'd0);
        smp();
        step();
        chk("add_not_yet", 32'(rsp_valid), 32'd0);
        step();
        chk("add_valid",  32'(rsp_valid),  32'd1);
        chk("add_result", 32'(rsp_result), 32'h8000);
        chk("add_flags",  32'(rsp_flags),  32'b100);
        quiesce();

        // MUL held for its full latency.
        adv();
        set_req(1, 4'd5, 16'h0003, 16'h0005, 5'd0);
        smp();
        for (int k = 0; k < ML; k++) begin
            step();
            chk("mul_hold_alu", 32'({alu_opcode, alu_input1, alu_input2[11:0]}), 32'h5_0003_005);
            chk("mul_no_rsp",   32'(rsp_valid), 32'd0);
        end
        step();
        chk("mul_valid",  32'(rsp_valid),  32'd1);
        chk("mul_result", 32'(rsp_result), 32'h000F);
        quiesce();

        // Illegal opcode answers the next cycle with an error.
        adv();
        set_req(2, 4'd13, 16'h1234, 16'h5678, 5'd3);
        smp();
        step();
        chk("ill_valid", 32'(rsp_valid), 32'd1);
        chk("ill_err",   32'(rsp_err),   32'd1);
        chk("ill_data",  32'({rsp_result, rsp_flags}), 32'd0);
        quiesce();

        // Back-pressure: response stalls, no grants while it waits.
        ready_mode = 2;
        adv();
        set_req(3, 4'd1, 16'h0005, 16'h0007, 5'd0);
        set_req(0, 4'd2, 16'h00FF, 16'h0F0F, 5'd0);
        set_req(1, 4'd3, 16'h1000, 16'h0001, 5'd0);
        smp();
        repeat (2) step();
        chk("stall_valid", 32'(rsp_valid), 32'd1);
        repeat (5) step();
        ready_mode = 1;
        repeat (6) step();
        quiesce();

        // Reset while an op is executing: nothing may come out afterwards.
        adv();
        set_req(0, 4'd0, 16'h1111, 16'h2222, 5'd0);
        smp();
        adv();
        req_valid = '0;
        smp();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp",   32'({rsp_valid, rsp_id, rsp_err, rsp_flags}), 32'd0);
        chk("mid_rst_alu",   {alu_input1, alu_input2}, 32'd0);
        chk("mid_rst_other", 32'({req_ready, alu_opcode, alu_shift, rsp_result}), 32'd0);
`ifdef ALU_REQ_SCHED_STATS_EN
        chk("mid_rst_stats", 32'(grant_cnt != '0), 32'd0);
`endif
        sbq.delete();
        outstanding = 0;
        last_g      = NR - 1;
        pend_acc    = '0;
        for (int i = 0; i < NR; i++) gcount[i] = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) step();

        // Random traffic against the reference model.
        rnd_en     = 1'b1;
        ready_mode = 0;
        repeat (1500) step();
        rnd_en     = 1'b0;
        ready_mode = 1;
        quiesce();

`ifdef ALU_REQ_SCHED_STATS_EN
        for (int i = 0; i < NR; i++) chk("stat_count", 32'(grant_cnt[i*16 +: 16]), 32'(gcount[i]));
        adv();
        stat_clr = 1'b1;
        set_req(0, 4'd0, 16'h0001, 16'h0001, 5'd0);
        smp();
        adv();
        stat_clr = 1'b0;
        smp();
        chk("stat_clear_wins", 32'(grant_cnt != '0), 32'd0);
        quiesce();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
